// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline control path:
// result-select, forwarding-select and hazard FSM state.
package riscv_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and hazard_ctrl.
// master: datapath (drives stage regs/ctrl); slave: hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CW = 16
);
  logic [4:0]    Rs1D, Rs2D;
  logic [4:0]    Rs1E, Rs2E, RdE;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE;
  logic [4:0]    RdM;
  logic          RegWriteM;
  logic          MemReqM;
  logic          MemReadyM;
  logic [4:0]    RdW;
  logic          RegWriteW;
  logic          StallF, StallD;
  logic          StallE, StallM;
  logic          FlushD, FlushE, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          MemTimeout;
  logic [CW-1:0] MemStallCnt;
  logic [CW-1:0] LoadUseCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE,
    output ResultSrcE, PCSrcE,
    output RdM, RegWriteM, MemReqM, MemReadyM,
    output RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE,
    input  MemTimeout, MemStallCnt, LoadUseCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE,
    input  ResultSrcE, PCSrcE,
    input  RdM, RegWriteM, MemReqM, MemReadyM,
    input  RdW, RegWriteW,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE,
    output MemTimeout, MemStallCnt, LoadUseCnt
  );

endinterface

// File: rtl/fwd_sel.sv
// Operand forward select for one E-stage source register.
// rs vs rdm/rdw; M wins over W; x0 never forwards.
module fwd_sel
  import riscv_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rdm,
  input  logic       regwritem,
  input  logic [4:0] rdw,
  input  logic       regwritew,
  output logic [1:0] fwd
);

  logic m_hit;
  logic w_hit;

  assign m_hit = regwritem && (rdm != 5'd0)
              && (rdm == rs);
  assign w_hit = regwritew && (rdw != 5'd0)
              && (rdw == rs) && !m_hit;

  always_comb begin
    fwd = FWD_RF;
    unique case (1'b1)
      m_hit:   fwd = FWD_MEM;
      w_hit:   fwd = FWD_WB;
      default: fwd = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control with a memory-wait FSM.
// Ports: clk, rst_n (async low), hz (slave bundle).
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WLAST =
    WW'(TIMEOUT - 1);

  hz_state_t     state, state_n;
  logic [WW-1:0] waitcnt, waitcnt_n;
  logic          timeout_q;
  logic [CW-1:0] memcnt_q, lucnt_q;
  logic          memhold;
  logic          lwstall;
  logic          mem_miss;

  fwd_sel u_fwd_a (
    .rs        (hz.Rs1E),
    .rdm       (hz.RdM),
    .regwritem (hz.RegWriteM),
    .rdw       (hz.RdW),
    .regwritew (hz.RegWriteW),
    .fwd       (hz.ForwardAE)
  );

  fwd_sel u_fwd_b (
    .rs        (hz.Rs2E),
    .rdm       (hz.RdM),
    .regwritem (hz.RegWriteM),
    .rdw       (hz.RdW),
    .regwritew (hz.RegWriteW),
    .fwd       (hz.ForwardBE)
  );

  assign mem_miss = hz.MemReqM && !hz.MemReadyM;

  assign memhold =
    ((state == RUN) && mem_miss) ||
    ((state == MEM_WAIT) && !hz.MemReadyM) ||
    (state == ERROR);

  assign lwstall =
    (hz.ResultSrcE == RES_MEM) &&
    (hz.RdE != 5'd0) &&
    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_comb begin
    state_n   = state;
    waitcnt_n = waitcnt;
    unique case (state)
      RUN: begin
        if (mem_miss) begin
          state_n   = MEM_WAIT;
          waitcnt_n = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM) begin
          state_n   = RUN;
          waitcnt_n = '0;
        end else if (waitcnt == WLAST) begin
          state_n = ERROR;
        end else begin
          waitcnt_n = waitcnt + WW'(1);
        end
      end
      ERROR: begin
        state_n = ERROR;
      end
      default: begin
        state_n   = RUN;
        waitcnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      waitcnt <= '0;
    end else begin
      state   <= state_n;
      waitcnt <= waitcnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (state_n == ERROR) begin
      timeout_q <= 1'b1;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memcnt_q <= '0;
      lucnt_q  <= '0;
    end else begin
      if (memhold && (state != ERROR)
          && (memcnt_q != '1)) begin
        memcnt_q <= memcnt_q + CW'(1);
      end
      if (lwstall && !memhold
          && (lucnt_q != '1)) begin
        lucnt_q <= lucnt_q + CW'(1);
      end
    end
  end

  // A memory hold freezes every stage and drops the
  // W result; a pending redirect waits in E until release.
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    if (memhold) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else begin
      hz.StallF = lwstall;
      hz.StallD = lwstall;
      hz.FlushE = lwstall || hz.PCSrcE;
      hz.FlushD = hz.PCSrcE;
    end
  end

  assign hz.MemTimeout  = timeout_q;
  assign hz.MemStallCnt = memcnt_q;
  assign hz.LoadUseCnt  = lucnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed steps plus random
// traffic against a cycle-level behavioural model.
module tb_hazard_ctrl;
  import riscv_pkg::*;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int MAXC = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CW(CW)) hif ();

  hazard_ctrl #(.TIMEOUT(TO), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif.slave)
  );

  int nvec = 0;
  int nerr = 0;

  // model: consecutive held cycles, sticky error, counts
  bit m_err;
  int m_held;
  int m_mc;
  int m_lc;

  logic [1:0] e_fa, e_fb;
  logic e_hold, e_lw;
  logic e_sf, e_sd, e_se, e_sm;
  logic e_fd, e_fe, e_fw;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_m(
      input logic [4:0] rs);
    if (hif.RegWriteM && hif.RdM != 0 &&
        hif.RdM == rs) return 2'b10;
    if (hif.RegWriteW && hif.RdW != 0 &&
        hif.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    bit waiting;
    waiting = (m_held > 0);
    e_fa = fwd_m(hif.Rs1E);
    e_fb = fwd_m(hif.Rs2E);
    e_lw = (hif.ResultSrcE == 2'b01) &&
           (hif.RdE != 0) &&
           (hif.RdE == hif.Rs1D ||
            hif.RdE == hif.Rs2D);
    if (m_err) e_hold = 1'b1;
    else if (waiting) e_hold = !hif.MemReadyM;
    else e_hold = hif.MemReqM && !hif.MemReadyM;
    if (e_hold) begin
      {e_sf, e_sd, e_se, e_sm, e_fw} = 5'h1f;
      e_fd = 1'b0;
      e_fe = 1'b0;
    end else begin
      e_sf = e_lw;
      e_sd = e_lw;
      e_se = 1'b0;
      e_sm = 1'b0;
      e_fw = 1'b0;
      e_fd = hif.PCSrcE;
      e_fe = e_lw | hif.PCSrcE;
    end
  endtask

  task automatic check_all();
    chk("ForwardAE", hif.ForwardAE, e_fa);
    chk("ForwardBE", hif.ForwardBE, e_fb);
    chk("StallF", hif.StallF, e_sf);
    chk("StallD", hif.StallD, e_sd);
    chk("StallE", hif.StallE, e_se);
    chk("StallM", hif.StallM, e_sm);
    chk("FlushD", hif.FlushD, e_fd);
    chk("FlushE", hif.FlushE, e_fe);
    chk("FlushW", hif.FlushW, e_fw);
    chk("MemTimeout", hif.MemTimeout, m_err);
    chk("MemStallCnt", hif.MemStallCnt, m_mc);
    chk("LoadUseCnt", hif.LoadUseCnt, m_lc);
  endtask

  task automatic model_tick();
    if (!m_err) begin
      if (e_hold) begin
        m_held++;
        if (m_mc < MAXC) m_mc++;
        if (m_held >= TO) m_err = 1'b1;
      end else begin
        m_held = 0;
      end
    end
    if (e_lw && !e_hold && m_lc < MAXC) m_lc++;
  endtask

  task automatic settle();
    #2;
    model_eval();
    check_all();
  endtask

  task automatic adv();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero();
    hif.Rs1D = 0; hif.Rs2D = 0;
    hif.Rs1E = 0; hif.Rs2E = 0; hif.RdE = 0;
    hif.ResultSrcE = 0; hif.PCSrcE = 0;
    hif.RdM = 0; hif.RegWriteM = 0;
    hif.MemReqM = 0; hif.MemReadyM = 0;
    hif.RdW = 0; hif.RegWriteW = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    zero();
    m_err = 0; m_held = 0; m_mc = 0; m_lc = 0;
    settle();
    chk("rst_stall", hif.StallM, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    zero();
    m_err = 0; m_held = 0; m_mc = 0; m_lc = 0;
    settle();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // forward priority
    hif.RdM = 5; hif.RdW = 5; hif.Rs1E = 5;
    hif.RegWriteM = 1; hif.RegWriteW = 1;
    settle();
    chk("fwd_m_prio", hif.ForwardAE, 2'b10);
    adv();
    hif.RdM = 0; hif.Rs2E = 5;
    settle();
    chk("fwd_w_a", hif.ForwardAE, 2'b01);
    chk("fwd_w_b", hif.ForwardBE, 2'b01);
    adv();

    // load-use
    zero();
    hif.ResultSrcE = 2'b01; hif.RdE = 3;
    hif.Rs2D = 3;
    settle();
    chk("lu_stallf", hif.StallF, 1'b1);
    chk("lu_flushe", hif.FlushE, 1'b1);
    adv();
    zero();
    settle();
    chk("lu_cnt", hif.LoadUseCnt, 1);
    adv();
    hif.ResultSrcE = 2'b01; hif.RdE = 0;
    settle();
    chk("lu_x0", hif.StallF, 1'b0);
    adv();

    // branch flush, alone and with load-use
    zero();
    hif.PCSrcE = 1;
    settle();
    chk("br_flushd", hif.FlushD, 1'b1);
    chk("br_stalld", hif.StallD, 1'b0);
    adv();
    hif.ResultSrcE = 2'b01; hif.RdE = 7;
    hif.Rs1D = 7;
    settle();
    chk("brlu_fd", hif.FlushD, 1'b1);
    chk("brlu_sf", hif.StallF, 1'b1);
    adv();

    // single-cycle access: no stall
    zero();
    hif.MemReqM = 1; hif.MemReadyM = 1;
    settle();
    chk("mem1_stall", hif.StallM, 1'b0);
    adv();

    // multi-cycle access released on ready
    hif.MemReadyM = 0;
    for (int i = 0; i < TO - 1; i++) begin
      settle();
      chk("memw_stall", hif.StallM, 1'b1);
      adv();
      hif.MemReqM = 0;
    end
    hif.MemReadyM = 1;
    settle();
    chk("memw_rel", hif.StallF, 1'b0);
    adv();
    zero();
    settle();
    chk("memw_cnt", hif.MemStallCnt, TO - 1);
    adv();

    // redirect held during a memory stall
    hif.MemReqM = 1; hif.PCSrcE = 1;
    settle();
    chk("brst_fd0", hif.FlushD, 1'b0);
    adv();
    hif.MemReqM = 0;
    settle();
    chk("brst_fe0", hif.FlushE, 1'b0);
    adv();
    hif.MemReadyM = 1;
    settle();
    chk("brst_fd1", hif.FlushD, 1'b1);
    chk("brst_fe1", hif.FlushE, 1'b1);
    adv();

    // timeout into ERROR, ready ignored, then reset
    zero();
    hif.MemReqM = 1;
    for (int i = 0; i < TO; i++) begin
      settle();
      adv();
    end
    hif.MemReadyM = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("err_to", hif.MemTimeout, 1'b1);
      chk("err_hold", hif.StallF, 1'b1);
      adv();
    end
    do_reset();
    settle();
    chk("post_rst_to", hif.MemTimeout, 1'b0);
    adv();

    // load-use counter saturation
    hif.ResultSrcE = 2'b01; hif.RdE = 9;
    hif.Rs1D = 9;
    for (int i = 0; i < MAXC + 3; i++) begin
      settle();
      adv();
    end
    settle();
    chk("lu_sat", hif.LoadUseCnt, MAXC);
    adv();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      hif.Rs1D = 5'($urandom_range(0, 3));
      hif.Rs2D = 5'($urandom_range(0, 3));
      hif.Rs1E = 5'($urandom_range(0, 3));
      hif.Rs2E = 5'($urandom_range(0, 3));
      hif.RdE  = 5'($urandom_range(0, 3));
      hif.RdM  = 5'($urandom_range(0, 3));
      hif.RdW  = 5'($urandom_range(0, 3));
      hif.ResultSrcE = 2'($urandom_range(0, 2));
      hif.PCSrcE = ($urandom_range(0, 5) == 0);
      hif.RegWriteM = 1'($urandom_range(0, 1));
      hif.RegWriteW = 1'($urandom_range(0, 1));
      hif.MemReqM = ($urandom_range(0, 3) == 0);
      hif.MemReadyM = ($urandom_range(0, 9) < 6);
      settle();
      adv();
      if (m_err) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
